// File: rtl/song_sequencer.sv
// song_sequencer: steps through one song of the shared note ROM and plays it.
// Each entry is fetched with a two-edge ROM latency and decoded. Its note is
// held for dur beats and followed by a silent articulation gap. Playback can
// be paused (note muted, time frozen) or aborted with stop.
module song_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [1:0]        song_select,
  output logic [ADDR_W+1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [3:0]        note_out,
  output logic [1:0]        octave_out,
  output logic [6:0]        led_out,
  output logic [3:0]        num,
  output logic              busy,
  output logic              done
);

  localparam int CYC_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CYC_W-1:0]  BEAT_LAST = CYC_W'(BEAT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] IDX_LAST  = '1;
  localparam logic [3:0]        NOTE_END  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state;
  logic [1:0]         song;
  logic [ADDR_W-1:0]  idx;
  logic [7:0]         unit_cnt;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [3:0]         cur_note;

  logic [3:0]         rom_note;
  logic [1:0]         rom_oct;
  logic [7:0]         rom_dur;
  logic               unused_rom_bits;
  logic               beat_last;
  logic               play_last;
  logic               gap_last;
  logic               idx_last;

  // One-hot LED for notes do..si; rests, end markers and other codes light nothing.
  function automatic logic [6:0] led_decode(input logic [3:0] n);
    logic [6:0] l;
    l = '0;
    case (n)
      4'd1:    l = 7'b0000001;
      4'd2:    l = 7'b0000010;
      4'd3:    l = 7'b0000100;
      4'd4:    l = 7'b0001000;
      4'd5:    l = 7'b0010000;
      4'd6:    l = 7'b0100000;
      4'd7:    l = 7'b1000000;
      default: l = '0;
    endcase
    return l;
  endfunction

  // Position digit shown on the display: entry index modulo 10.
  function automatic logic [3:0] mod10(input logic [ADDR_W-1:0] v);
    return 4'(32'(v) % 32'd10);
  endfunction

  // A zero duration still plays for one unit.
  function automatic logic [7:0] unit_load(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

  assign rom_addr        = {song, idx};
  assign rom_note        = rom_data[15:12];
  assign rom_oct         = rom_data[11:10];
  assign rom_dur         = rom_data[7:0];
  assign unused_rom_bits = ^rom_data[9:8];

  assign beat_last = (cyc_cnt == BEAT_LAST);
  assign play_last = beat_last && (unit_cnt == 8'd1);
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign idx_last  = (idx == IDX_LAST);

  // Playback state machine with all outputs registered; stop overrides everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      song       <= '0;
      idx        <= '0;
      unit_cnt   <= '0;
      cyc_cnt    <= '0;
      gap_cnt    <= '0;
      cur_note   <= '0;
      note_out   <= '0;
      octave_out <= '0;
      led_out    <= '0;
      num        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (stop) begin
      state      <= S_IDLE;
      song       <= '0;
      idx        <= '0;
      unit_cnt   <= '0;
      cyc_cnt    <= '0;
      gap_cnt    <= '0;
      cur_note   <= '0;
      note_out   <= '0;
      octave_out <= '0;
      led_out    <= '0;
      num        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            song  <= song_select;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end

        S_FETCH: state <= S_WAIT;

        S_WAIT: state <= S_DECODE;

        S_DECODE: begin
          if (rom_note == NOTE_END) begin
            note_out   <= '0;
            octave_out <= '0;
            led_out    <= '0;
            num        <= '0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            cur_note   <= rom_note;
            note_out   <= rom_note;
            octave_out <= rom_oct;
            led_out    <= led_decode(rom_note);
            num        <= mod10(idx);
            unit_cnt   <= unit_load(rom_dur);
            cyc_cnt    <= '0;
            state      <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (pause) begin
            // Time frozen and tone muted; LED and octave keep showing the note.
            note_out <= '0;
          end else if (play_last) begin
            note_out <= '0;
            led_out  <= '0;
            cyc_cnt  <= '0;
            if (GAP_CYCLES == 0) begin
              if (idx_last) begin
                octave_out <= '0;
                num        <= '0;
                done       <= 1'b1;
                state      <= S_DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= S_FETCH;
              end
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end else begin
            note_out <= cur_note;
            if (beat_last) begin
              cyc_cnt  <= '0;
              unit_cnt <= unit_cnt - 8'd1;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
        end

        S_GAP: begin
          if (!pause) begin
            if (gap_last) begin
              gap_cnt <= '0;
              if (idx_last) begin
                octave_out <= '0;
                num        <= '0;
                done       <= 1'b1;
                state      <= S_DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= S_FETCH;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          song       <= '0;
          idx        <= '0;
          note_out   <= '0;
          octave_out <= '0;
          led_out    <= '0;
          num        <= '0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a timeline model builds the expected output trace
// of each run from the ROM contents and the pause schedule, and the DUT is
// compared against it every cycle, plus literal spot values per scenario.
module tb_song_sequencer;

  localparam int BEAT = 4;
  localparam int GAP  = 2;
  localparam int MAXT = 1024;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic [1:0] song_select;
  logic [7:0] rom_addr;
  logic [15:0] rom_data;
  logic [3:0] note_out;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  logic [3:0] num;
  logic       busy;
  logic       done;

  song_sequencer #(.ADDR_W(6), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .song_select (song_select),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .note_out    (note_out),
    .octave_out  (octave_out),
    .led_out     (led_out),
    .num         (num),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM with data arriving on the second edge after the address.
  logic [15:0] rom [0:255];
  logic [15:0] rom_p1;
  always @(posedge clk) begin
    rom_p1   <= rom[rom_addr];
    rom_data <= rom_p1;
  end

  int n_chk;
  int n_err;
  int scn;

  // Expected outputs after edge Ek of a run (E0 = start sampling edge).
  int exp_note [0:MAXT-1];
  int exp_oct  [0:MAXT-1];
  int exp_led  [0:MAXT-1];
  int exp_num  [0:MAXT-1];
  int exp_busy [0:MAXT-1];
  int exp_done [0:MAXT-1];
  int exp_len;
  // Input levels held during the cycle after edge Ek.
  bit pz [0:MAXT-1];
  bit st [0:MAXT-1];
  bit sp [0:MAXT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic logic [15:0] ent(input int n, input int o, input int d);
    return {4'(n), 2'(o), 2'b00, 8'(d)};
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < MAXT; i++) begin
      pz[i] = 1'b0; st[i] = 1'b0; sp[i] = 1'b0;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic push(input int n, input int o, input int l, input int u, input int b, input int d);
    exp_note[exp_len] = n; exp_oct[exp_len] = o; exp_led[exp_len] = l;
    exp_num[exp_len] = u; exp_busy[exp_len] = b; exp_done[exp_len] = d;
    exp_len++;
  endtask

  // Timeline model: three silent fetch cycles per entry, dur*BEAT audible
  // cycles (paused cycles add time and mute), GAP silent cycles, then next.
  task automatic build(input int song);
    int idx, k, oct, nm, rem, n, d, led;
    logic [15:0] w;
    exp_len = 0; k = 0; idx = 0; oct = 0; nm = 0;
    forever begin
      repeat (3) begin push(0, oct, 0, nm, 1, 0); k++; end
      w = rom[song * 64 + idx];
      n = int'(w[15:12]);
      if (n == 15) begin push(0, 0, 0, 0, 1, 1); push(0, 0, 0, 0, 0, 0); return; end
      oct = int'(w[11:10]);
      d   = (w[7:0] == 8'd0) ? 1 : int'(w[7:0]);
      nm  = idx % 10;
      led = (n >= 1 && n <= 7) ? (1 << (n - 1)) : 0;
      rem = d * BEAT;
      push(n, oct, led, nm, 1, 0);
      forever begin
        if (pz[k]) begin k++; push(0, oct, led, nm, 1, 0); end
        else begin rem--; k++; if (rem == 0) break; push(n, oct, led, nm, 1, 0); end
      end
      rem = GAP;
      if (rem > 0) begin
        push(0, oct, 0, nm, 1, 0);
        forever begin
          if (pz[k]) begin k++; push(0, oct, 0, nm, 1, 0); end
          else begin rem--; k++; if (rem == 0) break; push(0, oct, 0, nm, 1, 0); end
        end
      end
      if (idx == 63) begin push(0, 0, 0, 0, 1, 1); push(0, 0, 0, 0, 0, 0); return; end
      idx++;
    end
  endtask

  task automatic dut_pins(input int k);
    case (scn)
      1: begin
        if (k == 3)  begin check("basic_note", note_out, 3); check("basic_led", led_out, 7'b0000100); check("basic_oct", octave_out, 1); end
        if (k == 16) check("basic_done", done, 1);
        if (k == 17) check("basic_busy_low", busy, 0);
      end
      2: if (k == 20) begin check("rest_note5", note_out, 5); check("rest_num1", num, 1); end
      3: begin
        if (k == 12) begin check("pause_note", note_out, 0); check("pause_led", led_out, 7'b0000010); end
        if (k == 19) check("pause_resume", note_out, 2);
      end
      4: if (k == 19) check("stop_idx", rom_addr[5:0], 1);
      5: if (k == 3 || k == 300) check("sel_song", rom_addr[7:6], 2);
      6: if (k == 7) check("rst_pre_oct", octave_out, 3);
      default: ;
    endcase
  endtask

  task automatic cmp_trace(input int k);
    check("trace_note", note_out,   exp_note[k]);
    check("trace_oct",  octave_out, exp_oct[k]);
    check("trace_led",  led_out,    exp_led[k]);
    check("trace_num",  num,        exp_num[k]);
    check("trace_busy", busy,       exp_busy[k]);
    check("trace_done", done,       exp_done[k]);
  endtask

  task automatic run(input logic [1:0] sel0, input logic [1:0] sel1, input int rst_edge);
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b0; pause = 1'b0; song_select = sel0;
    @(posedge clk); #1;
    for (int k = 0; k < exp_len; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      start = st[k]; stop = sp[k]; pause = pz[k];
      if (k == 0) song_select = sel1;
      dut_pins(k);
      if (k == rst_edge) begin
        #2 reset = 1'b0;
        #1;
        check("rst_note", note_out, 0); check("rst_oct", octave_out, 0);
        check("rst_led", led_out, 0);   check("rst_num", num, 0);
        check("rst_busy", busy, 0);     check("rst_done", done, 0);
        start = 1'b0; stop = 1'b0; pause = 1'b0;
        return;
      end
      @(negedge clk);
      cmp_trace(k);
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0; n_err = 0; scn = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; song_select = 2'd0;
    clear_rom(); clear_stim();
    #1 reset = 1'b0;
    #1;
    check("reset_note", note_out, 0); check("reset_busy", busy, 0);
    check("reset_done", done, 0);     check("reset_addr", rom_addr, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Basic play
    scn = 1; clear_rom(); clear_stim();
    rom[0] = ent(3, 1, 2); rom[1] = ent(15, 0, 0);
    build(0);
    check("model_basic_len", exp_len, 18);
    check("model_basic_done", exp_done[16], 1);
    check("model_basic_note10", exp_note[10], 3);
    check("model_basic_note11", exp_note[11], 0);
    run(2'd0, 2'd0, -1);

    // Rest and zero duration
    scn = 2; clear_rom(); clear_stim();
    rom[0] = ent(0, 0, 3); rom[1] = ent(5, 2, 0); rom[2] = ent(15, 0, 0);
    build(0);
    check("model_rest_len", exp_len, 31);
    run(2'd0, 2'd0, -1);

    // Pause mid-note
    scn = 3; clear_rom(); clear_stim();
    rom[0] = ent(2, 0, 4); rom[1] = ent(15, 0, 0);
    for (int i = 8; i <= 17; i++) pz[i] = 1'b1;
    build(0);
    check("model_pause_n9", exp_note[9], 0);
    check("model_pause_n28", exp_note[28], 2);
    check("model_pause_n29", exp_note[29], 0);
    run(2'd0, 2'd0, -1);

    // Stop with pause, after an ignored start
    scn = 4; clear_rom(); clear_stim();
    rom[0] = ent(4, 2, 2); rom[1] = ent(6, 0, 2); rom[2] = ent(15, 0, 0);
    st[17] = 1'b1; sp[19] = 1'b1; pz[19] = 1'b1;
    build(0);
    exp_len = 21;
    exp_note[20] = 0; exp_oct[20] = 0; exp_led[20] = 0;
    exp_num[20] = 0; exp_busy[20] = 0; exp_done[20] = 0;
    run(2'd0, 2'd0, -1);
    check("stop_addr", rom_addr, 0);
    repeat (3) @(posedge clk);
    #1 check("stop_stays_idle", busy, 0);

    // Song select latched; 64 entries with no end marker
    scn = 5; clear_rom(); clear_stim();
    for (int i = 0; i < 64; i++) rom[128 + i] = ent((i % 7) + 1, i % 4, 1);
    build(2);
    check("model_sel_len", exp_len, 578);
    check("model_sel_num63", exp_num[570], 3);
    check("model_sel_note10", exp_note[93], 4);
    run(2'd2, 2'd1, -1);

    // Asynchronous reset mid-gap
    scn = 6; clear_rom(); clear_stim();
    rom[0] = ent(1, 3, 1); rom[1] = ent(15, 0, 0);
    build(0);
    run(2'd0, 2'd0, 7);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_release_busy", busy, 0);

    // Normal playback after reset
    scn = 1; clear_rom(); clear_stim();
    rom[0] = ent(3, 1, 2); rom[1] = ent(15, 0, 0);
    build(0);
    run(2'd0, 2'd0, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Plays a stored song, one note at a time, from a shared note ROM, and drives the note, octave, LED and digit signals used by auto and learn modes.
- It sequences the ROM fetch, times each note's duration, inserts a silent articulation gap between notes, and supports start, pause and stop.
- It sits between the song ROM and the tone generator / display path.

Parameters:
- ADDR_W, 6: index bits per song; each song is 2^ADDR_W entries.
- BEAT_CYCLES, 12_500_000: clk cycles per duration unit (1/8 s at 100 MHz).
- GAP_CYCLES, 2_500_000: silent clk cycles inserted after each note; 0 means no gap.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle pulse; begins playback of song_select.
- stop, input, 1: single-cycle pulse; aborts playback.
- pause, input, 1: level; freezes playback while high.
- song_select, input, 2: song number; sampled only when start is accepted.
- rom_addr, output, ADDR_W+2: {song, idx}; the ROM returns data on the 2nd edge after the address changes.
- rom_data, input, 16: [15:12] note (0 = rest, 1..7 = do..si, 15 = end marker); [11:10] octave; [9:8] ignored; [7:0] duration in units (0 is treated as 1).
- note_out, output, 4: note code to the tone generator; 0 = silence.
- octave_out, output, 2: octave of the current note.
- led_out, output, 7: one-hot LED, bit (note-1); all zero for a rest or silence.
- num, output, 4: BCD position digit, idx mod 10.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse on natural end of song.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; idx=0; song=0; counters 0; note_out=0; octave_out=0; led_out=0; num=0; busy=0; done=0.
- Registered outputs; rom_addr is combinational from the song/idx registers.
- States: IDLE, FETCH, WAIT, DECODE, PLAY, GAP, DONE.
- IDLE: all outputs 0. On start: latch song=song_select, set idx=0, go to FETCH.
- FETCH -> WAIT -> DECODE: one cycle each. ROM data is valid in DECODE.
- DECODE, end marker (note 15): go to DONE.
- DECODE, any other note:
  - load note_out, octave_out, led_out and num=idx mod 10;
  - load the unit counter with dur (min 1) and clear the cycle counter;
  - go to PLAY.
- Start-to-note latency: with the start sampling edge as E0, note_out shows the first note after E3.
- PLAY: lasts exactly dur*BEAT_CYCLES cycles.
  - The cycle counter wraps at BEAT_CYCLES-1 and decrements the unit counter.
  - On exit: note_out, led_out <= 0; go to GAP, or straight to advance if GAP_CYCLES=0.
- GAP: lasts exactly GAP_CYCLES cycles of silence, then advances.
- Advance:
  - if idx = 2^ADDR_W-1, go to DONE (no wrap into the next song);
  - otherwise idx+1 and go to FETCH.
- FETCH/WAIT/DECODE are silent, so the spacing between note starts is dur*BEAT_CYCLES + GAP_CYCLES + 3 cycles.
- DONE: done=1 for one cycle; clear all outputs; go to IDLE on the next edge.
- Pause, sampled in PLAY or GAP:
  - counters freeze;
  - note_out forced to 0, led_out and octave_out hold;
  - on release, the note resumes with its remaining time and the prior note_out is restored.
- Pause in FETCH/WAIT/DECODE is ignored: the state completes, and pause takes effect on the first PLAY cycle.
- Pause in IDLE has no effect.
- Stop: from any state, the next edge goes to IDLE with all outputs 0 and done not asserted.
- Simultaneous events:
  - stop has priority over start and pause;
  - stop and start together in IDLE stay in IDLE;
  - start outside IDLE is ignored;
  - song_select changes after start is accepted are ignored until the next start.
- Assertion of reset mid-note clears immediately; there is no done pulse.

Test Plan:
- Use BEAT_CYCLES=4 and GAP_CYCLES=2 in all scenarios.
- Basic play: ROM song0 = {3,oct1,dur2},{15}; start at E0 -> note_out=3, octave_out=1, led_out=7'b0000100 from E3 for 8 cycles; note_out=0 for 2 gap cycles; end marker reached; done pulses one cycle; busy falls the cycle after done.
- Rest and zero duration: entries {0,dur3},{5,dur0},{15} -> note_out=0 for 12 cycles; 2-cycle gap plus 3 fetch cycles; note_out=5 for 4 cycles (dur 0 treated as 1); num shows 0 then 1.
- Pause mid-note: {2,dur4}, pause high for 10 cycles starting at the 6th PLAY cycle -> note_out=0 and led_out=7'b0000010 during the pause; after release note_out=2 for exactly 10 more cycles; total PLAY time 16 cycles.
- Stop priority: stop and pause asserted together mid-PLAY -> next cycle IDLE, all outputs 0, done=0; a start issued during PLAY produces no restart of idx.
- Song select and wrap: song_select=2 at start, changed to 1 afterwards -> rom_addr upper bits stay 2'b10; a song with no end marker plays 64 entries then pulses done; num sequence 0..9,0..9,...,3.
- Asynchronous reset: reset low mid-GAP, between clock edges -> outputs 0 immediately; after release, busy=0 and start works normally.
